// File: rtl/data_mem_responder_if.sv
// Request/response handshake bundle between the CPU M stage
// and the data-memory responder.
interface data_mem_responder_if #(
  parameter int ADDR_WIDTH = 32
) ();
  logic                  req_valid;
  logic                  req_ready;
  logic                  req_write;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic [31:0]           req_wdata;
  logic                  resp_valid;
  logic                  resp_ready;
  logic [31:0]           resp_rdata;
  logic                  resp_err;

  modport master (
    output req_valid,
    output req_write,
    output req_addr,
    output req_wdata,
    output resp_ready,
    input  req_ready,
    input  resp_valid,
    input  resp_rdata,
    input  resp_err
  );

  modport slave (
    input  req_valid,
    input  req_write,
    input  req_addr,
    input  req_wdata,
    input  resp_ready,
    output req_ready,
    output resp_valid,
    output resp_rdata,
    output resp_err
  );
endinterface

// File: rtl/data_mem_responder.sv
// Multi-cycle data memory: one request at a time, access performed
// LATENCY cycles after accept, response held until consumed.
module data_mem_responder #(
  parameter int ADDR_WIDTH  = 32,
  parameter int DEPTH_WORDS = 256,
  parameter int LATENCY     = 2
) (
  input logic                 clk,
  input logic                 rst,
  data_mem_responder_if.slave bus
);
  localparam int IW = (DEPTH_WORDS > 1) ?
                      $clog2(DEPTH_WORDS) : 1;
  localparam int CW = $clog2(LATENCY + 1);
  localparam logic [CW-1:0] CNT_INIT =
    (LATENCY >= 2) ? CW'(LATENCY - 2) : '0;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } state_t;

  state_t                state;
  logic [CW-1:0]         cnt;
  logic                  lat_write;
  logic [ADDR_WIDTH-1:0] lat_addr;
  logic [31:0]           lat_wdata;
  logic [31:0]           mem [DEPTH_WORDS];

  logic                  req_ready_q;
  logic                  resp_valid_q;
  logic [31:0]           resp_rdata_q;
  logic                  resp_err_q;

  logic                  acc_write;
  logic [ADDR_WIDTH-1:0] acc_addr;
  logic [31:0]           acc_wdata;
  logic [ADDR_WIDTH-3:0] acc_widx;
  logic [IW-1:0]         acc_midx;
  logic                  acc_err;
  logic                  enter_resp;

  // With LATENCY=1 the access happens on the accept edge,
  // so it must use the live request rather than the latch.
  always_comb begin
    if (state == IDLE) begin
      acc_write = bus.req_write;
      acc_addr  = bus.req_addr;
      acc_wdata = bus.req_wdata;
    end else begin
      acc_write = lat_write;
      acc_addr  = lat_addr;
      acc_wdata = lat_wdata;
    end
    acc_widx = acc_addr[ADDR_WIDTH-1:2];
    acc_midx = acc_widx[IW-1:0];
    acc_err  = (acc_addr[1:0] != 2'b00) ||
               ({2'b00, acc_widx} >=
                ADDR_WIDTH'(DEPTH_WORDS));
    enter_resp =
      ((state == IDLE) && bus.req_valid &&
       (LATENCY == 1)) ||
      ((state == WAIT) && (cnt == '0));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      cnt          <= '0;
      lat_write    <= 1'b0;
      lat_addr     <= '0;
      lat_wdata    <= '0;
      req_ready_q  <= 1'b1;
      resp_valid_q <= 1'b0;
      resp_rdata_q <= '0;
      resp_err_q   <= 1'b0;
      for (int i = 0; i < DEPTH_WORDS; i++) begin
        mem[i] <= '0;
      end
    end else begin
      unique case (state)
        IDLE: begin
          if (bus.req_valid) begin
            lat_write   <= bus.req_write;
            lat_addr    <= bus.req_addr;
            lat_wdata   <= bus.req_wdata;
            req_ready_q <= 1'b0;
            if (LATENCY == 1) begin
              state <= RESP;
            end else begin
              state <= WAIT;
              cnt   <= CNT_INIT;
            end
          end
        end
        WAIT: begin
          if (cnt == '0) begin
            state <= RESP;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        RESP: begin
          if (bus.resp_ready) begin
            state        <= IDLE;
            req_ready_q  <= 1'b1;
            resp_valid_q <= 1'b0;
            resp_rdata_q <= '0;
            resp_err_q   <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase

      if (enter_resp) begin
        resp_valid_q <= 1'b1;
        resp_err_q   <= acc_err;
        resp_rdata_q <= (acc_write || acc_err) ?
                        '0 : mem[acc_midx];
        if (acc_write && !acc_err) begin
          mem[acc_midx] <= acc_wdata;
        end
      end
    end
  end

  assign bus.req_ready  = req_ready_q;
  assign bus.resp_valid = resp_valid_q;
  assign bus.resp_rdata = resp_rdata_q;
  assign bus.resp_err   = resp_err_q;
endmodule

// File: tb/tb_data_mem_responder.sv
// Bench for data_mem_responder: directed vector table, reset-abort
// sequence, then random traffic against a word-array model.
module tb_data_mem_responder;
  localparam int AW    = 32;
  localparam int DEPTH = 256;
  localparam int LAT   = 2;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  data_mem_responder_if #(.ADDR_WIDTH(AW)) bus ();

  data_mem_responder #(
    .ADDR_WIDTH (AW),
    .DEPTH_WORDS(DEPTH),
    .LATENCY    (LAT)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  typedef struct {
    logic        write;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    logic        exp_err;
    int          hold;
  } vec_t;

  int          n_pass  = 0;
  int          n_total = 0;
  logic [31:0] model_mem [DEPTH];
  vec_t        vecs [12];

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_total++;
    if (act !== exp)
      $display("FAIL %s: got 0x%08h, want 0x%08h",
               name, act, exp);
    else
      n_pass++;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_clear();
    for (int i = 0; i < DEPTH; i++) model_mem[i] = '0;
  endtask

  function automatic logic model_err(input logic [31:0] a);
    return (a % 4 != 0) || ((a / 4) >= DEPTH);
  endfunction

  task automatic run_req(input  logic        wr,
                         input  logic [31:0] addr,
                         input  logic [31:0] wdata,
                         input  int          hold,
                         output logic [31:0] rdata,
                         output logic        err);
    int          lat;
    logic [31:0] exp_rd;
    logic        exp_e;
    exp_e  = model_err(addr);
    exp_rd = (wr || exp_e) ? 32'h0 : model_mem[addr / 4];
    if (wr && !exp_e) model_mem[addr / 4] = wdata;

    chk("req_ready_idle", 32'(bus.req_ready), 32'd1);
    bus.req_valid = 1'b1;
    bus.req_write = wr;
    bus.req_addr  = addr;
    bus.req_wdata = wdata;
    tick();
    bus.req_valid = 1'b0;
    bus.req_wdata = $urandom;
    lat = 0;
    for (int n = 1; n <= 20; n++) begin
      if (bus.resp_valid) begin
        lat = n;
        break;
      end
      chk("req_ready_busy", 32'(bus.req_ready), 32'd0);
      tick();
    end
    chk("latency", 32'(lat), 32'(LAT));
    rdata = bus.resp_rdata;
    err   = bus.resp_err;
    chk("rdata_model", rdata, exp_rd);
    chk("err_model", 32'(err), 32'(exp_e));
    chk("req_ready_resp", 32'(bus.req_ready), 32'd0);

    for (int h = 0; h < hold; h++) begin
      bus.req_valid = 1'($urandom_range(0, 1));
      bus.req_write = 1'($urandom_range(0, 1));
      bus.req_addr  = 32'($urandom_range(0, 255)) << 2;
      bus.req_wdata = $urandom;
      tick();
      chk("hold_valid", 32'(bus.resp_valid), 32'd1);
      chk("hold_rdata", bus.resp_rdata, rdata);
      chk("hold_err", 32'(bus.resp_err), 32'(err));
      chk("hold_ready", 32'(bus.req_ready), 32'd0);
    end

    bus.req_valid  = 1'b0;
    bus.resp_ready = 1'b1;
    tick();
    bus.resp_ready = 1'b0;
    chk("post_valid", 32'(bus.resp_valid), 32'd0);
    chk("post_ready", 32'(bus.req_ready), 32'd1);
    chk("post_rdata", bus.resp_rdata, 32'h0);
    chk("post_err", 32'(bus.resp_err), 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [31:0] rd;
    logic        er;
    int          r;
    logic [31:0] a;

    vecs[0]  = '{1'b0, 32'h10,  32'h0,        32'h0,        1'b0, 0};
    vecs[1]  = '{1'b1, 32'h8,   32'hDEADBEEF, 32'h0,        1'b0, 0};
    vecs[2]  = '{1'b0, 32'h8,   32'h0,        32'hDEADBEEF, 1'b0, 0};
    vecs[3]  = '{1'b1, 32'h6,   32'h12345678, 32'h0,        1'b1, 0};
    vecs[4]  = '{1'b0, 32'h4,   32'h0,        32'h0,        1'b0, 0};
    vecs[5]  = '{1'b0, 32'h400, 32'h0,        32'h0,        1'b1, 0};
    vecs[6]  = '{1'b0, 32'h3FC, 32'h0,        32'h0,        1'b0, 0};
    vecs[7]  = '{1'b1, 32'h404, 32'hA5A5A5A5, 32'h0,        1'b1, 0};
    vecs[8]  = '{1'b0, 32'h4,   32'h0,        32'h0,        1'b0, 5};
    vecs[9]  = '{1'b1, 32'h3FC, 32'h13572468, 32'h0,        1'b0, 0};
    vecs[10] = '{1'b0, 32'h3FC, 32'h0,        32'h13572468, 1'b0, 0};
    vecs[11] = '{1'b0, 32'hFFFFFFFC, 32'h0,   32'h0,        1'b1, 0};

    bus.req_valid  = 1'b0;
    bus.req_write  = 1'b0;
    bus.req_addr   = '0;
    bus.req_wdata  = '0;
    bus.resp_ready = 1'b0;
    rst = 1'b1;
    model_clear();
    tick();
    tick();
    rst = 1'b0;
    chk("rst_req_ready", 32'(bus.req_ready), 32'd1);
    chk("rst_resp_valid", 32'(bus.resp_valid), 32'd0);
    chk("rst_rdata", bus.resp_rdata, 32'h0);
    chk("rst_err", 32'(bus.resp_err), 32'd0);

    for (int i = 0; i < 12; i++) begin
      run_req(vecs[i].write, vecs[i].addr, vecs[i].wdata,
              vecs[i].hold, rd, er);
      chk($sformatf("vec%0d_rdata", i), rd, vecs[i].exp_rdata);
      chk($sformatf("vec%0d_err", i), 32'(er),
          32'(vecs[i].exp_err));
    end

    // Reset while a store is waiting: it must never commit.
    bus.req_valid = 1'b1;
    bus.req_write = 1'b1;
    bus.req_addr  = 32'h20;
    bus.req_wdata = 32'hCAFEF00D;
    tick();
    bus.req_valid = 1'b0;
    chk("abort_in_wait", 32'(bus.req_ready), 32'd0);
    rst = 1'b1;
    for (int c = 0; c < 3; c++) begin
      tick();
      chk("abort_rst_valid", 32'(bus.resp_valid), 32'd0);
    end
    rst = 1'b0;
    model_clear();
    for (int c = 0; c < 4; c++) begin
      chk("abort_valid", 32'(bus.resp_valid), 32'd0);
      chk("abort_ready", 32'(bus.req_ready), 32'd1);
      tick();
    end
    run_req(1'b0, 32'h20, 32'h0, 0, rd, er);
    chk("abort_load20", rd, 32'h0);
    run_req(1'b0, 32'h8, 32'h0, 0, rd, er);
    chk("abort_mem_cleared", rd, 32'h0);

    for (int t = 0; t < 80; t++) begin
      r = $urandom_range(0, 9);
      if (r < 7)
        a = 32'($urandom_range(0, 31)) << 2;
      else if (r == 7)
        a = (32'($urandom_range(0, 31)) << 2) +
            32'($urandom_range(1, 3));
      else if (r == 8)
        a = 32'($urandom_range(DEPTH, DEPTH + 40)) << 2;
      else
        a = 32'hFFFF_F000 + (32'($urandom_range(0, 31)) << 2);
      run_req(1'($urandom_range(0, 1)), a, $urandom,
              $urandom_range(0, 3), rd, er);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
